// File: rtl/writeback_queue_pkg.sv
// Shared CPU constants for the write-back path: default register widths and the r0 index.
package writeback_queue_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned R0_IDX         = 0;

endpackage

// File: rtl/wbq_fwd_match.sv
// Per-read-port lookup: newest occupied entry whose destination matches the read index.
module wbq_fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] rd_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [PTR_W-1:0]             head_i,
    input  logic [ADDR_W-1:0]            addr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (head) to youngest so later matches override earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (rd_i[idx] == addr_i) && (addr_i != ADDR_W'(R0_IDX))) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue draining one result per cycle into the register file,
// with two forwarding lookups for the operand latches.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_W-1:0]          in_rd_i,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       hold_i,
    output logic                       rf_we_o,
    output logic [ADDR_W-1:0]          rf_waddr_o,
    output logic [DATA_W-1:0]          rf_wdata_o,
    input  logic [ADDR_W-1:0]          fwd_addr_a_i,
    input  logic [ADDR_W-1:0]          fwd_addr_b_i,
    output logic                       fwd_hit_a_o,
    output logic                       fwd_hit_b_o,
    output logic [DATA_W-1:0]          fwd_data_a_o,
    output logic [DATA_W-1:0]          fwd_data_b_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_mask;
    logic [PTR_W-1:0]             offset;
    logic                         full, accept, push, drain;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign accept = in_valid_i && !full;
    // r0 writes complete the handshake but never occupy a slot.
    assign push   = accept && (in_rd_i != ADDR_W'(R0_IDX));
    assign drain  = (count_q != '0) && !hold_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (drain && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                rd_q[tail_q]   <= in_rd_i;
                data_q[tail_q] <= in_data_i;
            end
        end
    end

    // A slot is occupied when its distance from head is below the occupancy.
    always_comb begin
        valid_mask = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - head_q;
            valid_mask[i] = ({1'b0, offset} < count_q);
        end
    end

    assign in_ready_o = !full;
    assign rf_we_o    = drain;
    assign rf_waddr_o = rd_q[head_q];
    assign rf_wdata_o = data_q[head_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    wbq_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fwd_a (
        .rd_i    (rd_q),
        .data_i  (data_q),
        .valid_i (valid_mask),
        .head_i  (head_q),
        .addr_i  (fwd_addr_a_i),
        .hit_o   (fwd_hit_a_o),
        .data_o  (fwd_data_a_o)
    );

    wbq_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fwd_b (
        .rd_i    (rd_q),
        .data_i  (data_q),
        .valid_i (valid_mask),
        .head_i  (head_q),
        .addr_i  (fwd_addr_b_i),
        .hit_o   (fwd_hit_b_o),
        .data_o  (fwd_data_b_o)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a vector table plus hand-written multi-cycle sequences.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_addr_a, fwd_addr_b;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_data_a, fwd_data_b;
    logic [2:0]  count;
    logic        empty;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    writeback_queue #(
        .DATA_W (32),
        .ADDR_W (5),
        .DEPTH  (4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_rd_i      (in_rd),
        .in_data_i    (in_data),
        .hold_i       (hold),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .fwd_addr_a_i (fwd_addr_a),
        .fwd_addr_b_i (fwd_addr_b),
        .fwd_hit_a_o  (fwd_hit_a),
        .fwd_hit_b_o  (fwd_hit_b),
        .fwd_data_a_o (fwd_data_a),
        .fwd_data_b_o (fwd_data_b),
        .count_o      (count),
        .empty_o      (empty)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        hold;
        logic [4:0]  fa;
        logic [4:0]  fb;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_hit_a;
        logic [31:0] e_data_a;
        logic        e_hit_b;
        logic [31:0] e_data_b;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic h);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        hold     = h;
    endtask

    initial begin
        //        valid rd     data          hold fa     fb     rdy we waddr  wdata
        //        hit_a data_a        hit_b data_b        count
        vec[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF,
                   1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 3'd1};
        vec[2] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[3] = '{1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'h11,
                   1'b1, 32'h11, 1'b0, 32'h0, 3'd1};
        vec[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 32'h11,
                   1'b1, 32'h22, 1'b1, 32'h22, 3'd2};
        vec[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'h11,
                   1'b1, 32'h22, 1'b0, 32'h0, 3'd2};
        vec[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'h22,
                   1'b1, 32'h22, 1'b0, 32'h0, 3'd1};
        vec[7] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 3'd0};

        reset      = 1'b1;
        fwd_addr_a = 5'd0;
        fwd_addr_b = 5'd0;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.we", 32'(rf_we), 32'd0);
        chk("rst.waddr", 32'(rf_waddr), 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        chk("rst.hit_a", 32'(fwd_hit_a), 32'd0);
        chk("rst.data_b", fwd_data_b, 32'd0);
        reset = 1'b0;

        // Single write, forward-newest, r0 drop.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vec[i].valid, vec[i].rd, vec[i].data, vec[i].hold);
            fwd_addr_a = vec[i].fa;
            fwd_addr_b = vec[i].fb;
            #1;
            chk($sformatf("v%0d.ready", i), 32'(in_ready), 32'(vec[i].e_ready));
            chk($sformatf("v%0d.we", i), 32'(rf_we), 32'(vec[i].e_we));
            chk($sformatf("v%0d.waddr", i), 32'(rf_waddr), 32'(vec[i].e_waddr));
            chk($sformatf("v%0d.wdata", i), rf_wdata, vec[i].e_wdata);
            chk($sformatf("v%0d.hit_a", i), 32'(fwd_hit_a), 32'(vec[i].e_hit_a));
            chk($sformatf("v%0d.data_a", i), fwd_data_a, vec[i].e_data_a);
            chk($sformatf("v%0d.hit_b", i), 32'(fwd_hit_b), 32'(vec[i].e_hit_b));
            chk($sformatf("v%0d.data_b", i), fwd_data_b, vec[i].e_data_b);
            chk($sformatf("v%0d.count", i), 32'(count), 32'(vec[i].e_count));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vec[i].e_count == 3'd0));
        end

        // Full and backpressure: r5 refused until the first drain frees a slot.
        fwd_addr_a = 5'd0;
        fwd_addr_b = 5'd0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
            #1;
            chk($sformatf("full%0d.ready", i), 32'(in_ready), 32'(i <= 4));
            chk($sformatf("full%0d.count", i), 32'(count), 32'((i <= 4) ? i - 1 : 4));
            chk($sformatf("full%0d.we", i), 32'(rf_we), 32'd0);
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("bp.a.ready", 32'(in_ready), 32'd0);
        chk("bp.a.we", 32'(rf_we), 32'd1);
        chk("bp.a.waddr", 32'(rf_waddr), 32'd1);
        chk("bp.a.count", 32'(count), 32'd4);
        @(negedge clk);
        #1;
        chk("bp.b.ready", 32'(in_ready), 32'd1);
        chk("bp.b.waddr", 32'(rf_waddr), 32'd2);
        chk("bp.b.count", 32'(count), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp.c.waddr", 32'(rf_waddr), 32'd3);
        chk("bp.c.count", 32'(count), 32'd3);
        @(negedge clk);
        #1;
        chk("bp.d.waddr", 32'(rf_waddr), 32'd4);
        chk("bp.d.wdata", rf_wdata, 32'h104);
        @(negedge clk);
        #1;
        chk("bp.e.we", 32'(rf_we), 32'd1);
        chk("bp.e.waddr", 32'(rf_waddr), 32'd5);
        chk("bp.e.wdata", rf_wdata, 32'h105);
        chk("bp.e.count", 32'(count), 32'd1);
        @(negedge clk);
        #1;
        chk("bp.f.we", 32'(rf_we), 32'd0);
        chk("bp.f.count", 32'(count), 32'd0);

        // Steady enqueue+drain at count=2, tail and head crossing the 3->0 wrap.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(6 + k), 32'h200 + 32'(k), 1'b1);
        end
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(6 + k), 32'h200 + 32'(k), 1'b0);
            #1;
            chk($sformatf("wrap%0d.count", k), 32'(count), 32'd2);
            chk($sformatf("wrap%0d.we", k), 32'(rf_we), 32'd1);
            chk($sformatf("wrap%0d.wdata", k), rf_wdata, 32'h200 + 32'(k - 2));
        end
        for (int k = 8; k < 10; k++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 1'b0);
            #1;
            chk($sformatf("wrap%0d.waddr", k), 32'(rf_waddr), 32'(6 + k - 2));
            chk($sformatf("wrap%0d.wdata", k), rf_wdata, 32'h200 + 32'(k - 2));
        end

        // Reset mid-drain with three entries queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(10 + k), 32'h300 + 32'(k), 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        fwd_addr_a = 5'd11;
        #1;
        chk("rm.pre.we", 32'(rf_we), 32'd1);
        chk("rm.pre.count", 32'(count), 32'd3);
        chk("rm.pre.hit_a", 32'(fwd_hit_a), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rm.we", 32'(rf_we), 32'd0);
        chk("rm.count", 32'(count), 32'd0);
        chk("rm.empty", 32'(empty), 32'd1);
        chk("rm.hit_a", 32'(fwd_hit_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rm.post%0d.we", k), 32'(rf_we), 32'd0);
            chk($sformatf("rm.post%0d.count", k), 32'(count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
